// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the sequential carry-lookahead adder:
//   state_t   - FSM state encoding (IDLE / RUN / DONE)
//   SLICE_MAX - widest lookahead slice the slice logic is sized for
//   idx_w()   - width of an index counting 0..n-1 (at least 1 bit)
// No ports.
// -----------------------------------------------------------------------------
package adder_pkg;

    localparam int SLICE_MAX = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cla_seq_adder_if.sv
// -----------------------------------------------------------------------------
// cla_seq_adder_if
// Request/response bundle for the sequential adder.
//   master : drives start, a, b, carry_in, sub; observes busy, done, sum,
//            carry_out
//   slave  : the adder side of the same signals
// sub is carried in the bundle even when subtraction is compiled out; it is
// then simply left unconnected at the adder.
// -----------------------------------------------------------------------------
interface cla_seq_adder_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;

    modport master (
        output start, a, b, carry_in, sub,
        input  busy, done, sum, carry_out
    );

    modport slave (
        input  start, a, b, carry_in, sub,
        output busy, done, sum, carry_out
    );

endinterface

// File: rtl/cla_seq_adder_slice.sv
// -----------------------------------------------------------------------------
// cla_slice
// Purely combinational SLICE-bit carry-lookahead adder slice.
//   i_a, i_b : slice operand bits
//   i_cin    : carry into the slice
//   o_sum    : slice sum bits
//   o_cout   : carry out of the slice
// Every internal carry is formed directly from generate/propagate terms and
// i_cin (no ripple through earlier carries).
// -----------------------------------------------------------------------------
module cla_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] i_a,
    input  logic [SLICE-1:0] i_b,
    input  logic             i_cin,
    output logic [SLICE-1:0] o_sum,
    output logic             o_cout
);

    logic [SLICE-1:0] w_g;
    logic [SLICE-1:0] w_p;
    logic [SLICE:0]   w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // c[i+1] = OR_j ( g[j] & p[j+1..i] )  |  ( cin & p[0..i] )
    always_comb begin : p_lookahead
        logic w_acc;
        logic w_term;
        w_acc  = 1'b0;
        w_term = 1'b0;
        w_c    = '0;
        w_c[0] = i_cin;
        for (int i = 0; i < SLICE; i++) begin
            w_acc = 1'b0;
            for (int j = 0; j <= i; j++) begin
                w_term = w_g[j];
                for (int k = j + 1; k <= i; k++) begin
                    w_term = w_term & w_p[k];
                end
                w_acc = w_acc | w_term;
            end
            w_term = i_cin;
            for (int k = 0; k <= i; k++) begin
                w_term = w_term & w_p[k];
            end
            w_c[i+1] = w_acc | w_term;
        end
    end

    assign o_sum  = w_p ^ w_c[SLICE-1:0];
    assign o_cout = w_c[SLICE];

endmodule

// File: rtl/cla_seq_adder.sv
// -----------------------------------------------------------------------------
// cla_seq_adder
// Sequential adder: one SLICE-bit carry-lookahead slice per clock, reusing a
// single cla_slice instance; WIDTH/SLICE RUN cycles per operation.
//   clk, rst_n   : clock (rising edge) and asynchronous active-low reset
//   start        : begin an operation (accepted in IDLE or DONE)
//   a, b         : operands, latched on acceptance
//   carry_in     : initial carry (borrow-in when subtracting)
//   sub          : present only with ADDER_SUB_EN; 1 = a - b - carry_in
//   busy         : high while in RUN
//   done         : one-cycle pulse in DONE
//   sum          : registered result, updated on entry to DONE
//   carry_out    : registered final carry (1 = no borrow when subtracting)
// Compile-time option: define ADDER_SUB_EN to add the sub port.
// -----------------------------------------------------------------------------
module cla_seq_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
`ifdef ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IW     = idx_w(NSLICE);
    localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

    if ((SLICE < 1) || (SLICE > SLICE_MAX) || ((WIDTH % SLICE) != 0)) begin : g_bad_cfg
        $error("cla_seq_adder: WIDTH must be a multiple of SLICE, 1 <= SLICE <= SLICE_MAX");
    end

    state_t           r_state;
    state_t           w_next;
    logic             w_accept;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;      // running carry between slices
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_acc;        // partial result being assembled
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin_eff;
    logic [SLICE-1:0] w_slice_sum;
    logic             w_slice_cout;
    logic [WIDTH-1:0] w_acc_nxt;

    // Subtraction is a + ~b + ~borrow_in; invert on the way into the latch so
    // the datapath itself only ever adds.
`ifdef ADDER_SUB_EN
    assign w_b_eff   = sub ? ~b : b;
    assign w_cin_eff = sub ? ~carry_in : carry_in;
`else
    assign w_b_eff   = b;
    assign w_cin_eff = carry_in;
`endif

    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (r_idx == LAST) w_next = DONE;
            end
            DONE: begin
                done   = 1'b1;
                w_next = start ? RUN : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // ---------------- slice datapath ----------------
    cla_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .i_a    (r_a[r_idx*SLICE +: SLICE]),
        .i_b    (r_b[r_idx*SLICE +: SLICE]),
        .i_cin  (r_carry),
        .o_sum  (w_slice_sum),
        .o_cout (w_slice_cout)
    );

    // Full result including the slice being computed this cycle, so the last
    // slice can go straight into the output register on entry to DONE.
    always_comb begin
        w_acc_nxt = r_acc;
        w_acc_nxt[r_idx*SLICE +: SLICE] = w_slice_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= w_b_eff;
            r_carry <= w_cin_eff;
            r_idx   <= '0;
            r_acc   <= '0;
        end else if (r_state == RUN) begin
            r_acc   <= w_acc_nxt;
            r_carry <= w_slice_cout;
            if (r_idx == LAST) begin
                r_sum  <= w_acc_nxt;
                r_cout <= w_slice_cout;
            end else begin
                r_idx  <= r_idx + IW'(1);
            end
        end
    end

    assign sum       = r_sum;
    assign carry_out = r_cout;

endmodule
